// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic feeder: read FSM encoding and
// MSB-first lane extraction from a packed lane bus.
package systolic_pkg;

    typedef enum logic {R_IDLE, R_STREAM} feeder_state_t;

    localparam int LANE_MAX_W = 64;
    localparam int BUS_MAX_W  = 1024;

    // Lane idx of a bus with `lanes` lanes of `dw` bits; lane 0 sits at the MSB end.
    function automatic logic [LANE_MAX_W-1:0] lane_sel(input logic [BUS_MAX_W-1:0] bus,
                                                       input int idx, input int dw,
                                                       input int lanes);
        logic [LANE_MAX_W-1:0] mask;
        mask = (LANE_MAX_W'(1) << dw) - LANE_MAX_W'(1);
        return LANE_MAX_W'(bus >> (dw * (lanes - 1 - idx))) & mask;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_line.sv
// Per-lane delay line: `depth` register stages with synchronous clear.
// Depth 0 degenerates to a wire.
module skew_line #(
    parameter int data_size = 16,
    parameter int depth     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [data_size-1:0] d,
    output logic [data_size-1:0] q
);

    if (depth == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;
        assign q = d;
    end else begin : g_sr
        logic [data_size-1:0] sr [depth];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < depth; k++) sr[k] <= '0;
            end else begin
                sr[0] <= d;
                for (int k = 1; k < depth; k++) sr[k] <= sr[k-1];
            end
        end

        assign q = sr[depth-1];
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Ping-pong tile buffer feeding a systolic array: collects `size` beats per
// tile, then streams each tile gap-free with lane i delayed by i cycles.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [data_size*size-1:0] in_a,
    input  logic [data_size*size-1:0] in_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [data_size*size-1:0] a_out,
    output logic [data_size*size-1:0] b_out,
    output logic                      reset_counter,
    output logic                      out_valid
);

    localparam int W  = data_size * size;
    localparam int CW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CW-1:0] LAST = CW'(size - 1);

    logic [W-1:0]  bank_a [2][size];
    logic [W-1:0]  bank_b [2][size];
    logic [1:0]    full;
    logic [1:0]    full_set, full_clr;
    logic          wr_bank, rd_bank;
    logic [CW-1:0] wr_cnt, rd_cnt;
    feeder_state_t state;
    logic [W-1:0]  lane0_a, lane0_b;
    logic          xfer, wr_done, rd_active, rd_done;

    assign in_ready = !reset && !full[wr_bank];
    assign xfer     = in_valid && in_ready;
    assign wr_done  = xfer && (wr_cnt == LAST);

    // A full bank is read in the very cycle it becomes visible, so idle costs no extra latency.
    assign rd_active = (state == R_STREAM) || ((state == R_IDLE) && full[rd_bank]);
    assign rd_done   = rd_active && (rd_cnt == LAST);

    assign full_set = {wr_done && wr_bank, wr_done && !wr_bank};
    assign full_clr = {rd_done && rd_bank, rd_done && !rd_bank};

    always_ff @(posedge clk) begin
        if (xfer) begin
            bank_a[wr_bank][wr_cnt] <= in_a;
            bank_b[wr_bank][wr_cnt] <= in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (xfer) begin
            if (wr_cnt == LAST) begin
                wr_cnt  <= '0;
                wr_bank <= !wr_bank;
            end else begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Write and read completions in one cycle always hit different banks.
    always_ff @(posedge clk) begin
        if (reset) full <= '0;
        else       full <= (full & ~full_clr) | full_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_cnt        <= '0;
            lane0_a       <= '0;
            lane0_b       <= '0;
            reset_counter <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            reset_counter <= rd_active && (rd_cnt == '0);
            out_valid     <= rd_active;
            if (rd_active) begin
                lane0_a <= bank_a[rd_bank][rd_cnt];
                lane0_b <= bank_b[rd_bank][rd_cnt];
                if (rd_done) begin
                    rd_cnt  <= '0;
                    rd_bank <= !rd_bank;
                    state   <= full[!rd_bank] ? R_STREAM : R_IDLE;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                    state  <= R_STREAM;
                end
            end else begin
                lane0_a <= '0;
                lane0_b <= '0;
                state   <= R_IDLE;
            end
        end
    end

    for (genvar j = 0; j < size; j++) begin : g_lane
        skew_line #(.data_size(data_size), .depth(j)) u_skew_a (
            .clk   (clk),
            .reset (reset),
            .d     (data_size'(lane_sel(BUS_MAX_W'(lane0_a), j, data_size, size))),
            .q     (a_out[data_size*(size-j)-1 -: data_size])
        );
        skew_line #(.data_size(data_size), .depth(j)) u_skew_b (
            .clk   (clk),
            .reset (reset),
            .d     (data_size'(lane_sel(BUS_MAX_W'(lane0_b), j, data_size, size))),
            .q     (b_out[data_size*(size-j)-1 -: data_size])
        );
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: directed table for one tile, pattern runs for
// back-to-back/stall/reset cases, and a per-cycle scoreboard monitor throughout.
module tb_systolic_skew_feeder;

    localparam int SZ = 3;
    localparam int DW = 16;
    localparam int W  = SZ * DW;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_a, in_b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_out, b_out;
    logic         reset_counter;
    logic         out_valid;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.size(SZ), .data_size(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .a_out         (a_out),
        .b_out         (b_out),
        .reset_counter (reset_counter),
        .out_valid     (out_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] lane(input logic [W-1:0] v, input int i);
        return v[W-1-DW*i -: DW];
    endfunction

    function automatic logic [W-1:0] beat_vec(input int k, input logic [DW-1:0] off);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < SZ; j++) v[W-1-DW*j -: DW] = DW'((3*k + j + 1) << 8) + off;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_vec();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: completed tiles queue up in beat order; lane-0 history models the skew.
    logic [W-1:0] q_a[$], q_b[$], part_a[$], part_b[$];
    logic [W-1:0] hist_a [SZ];
    logic [W-1:0] hist_b [SZ];
    bit           rst_prev = 1'b1;
    int           pos = 0;

    always @(negedge clk) begin
        logic [W-1:0] ca, cb, ea, eb;
        if (rst_prev) begin
            q_a.delete(); q_b.delete(); part_a.delete(); part_b.delete();
            pos = 0;
            for (int i = 0; i < SZ; i++) begin hist_a[i] = '0; hist_b[i] = '0; end
            chk("post_reset_valid", out_valid, 0);
        end
        ca = '0;
        cb = '0;
        if (out_valid && !rst_prev) begin
            if (q_a.size() == 0) begin
                chk("spurious_valid", out_valid, 0);
            end else begin
                ca = q_a.pop_front();
                cb = q_b.pop_front();
            end
            chk("reset_counter", reset_counter, (pos == 0));
            pos = (pos + 1) % SZ;
        end else if (!out_valid) begin
            if (pos != 0) chk("mid_tile_bubble", out_valid, 1);
            chk("reset_counter_idle", reset_counter, 0);
        end
        for (int i = SZ - 1; i > 0; i--) begin hist_a[i] = hist_a[i-1]; hist_b[i] = hist_b[i-1]; end
        hist_a[0] = ca;
        hist_b[0] = cb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < SZ; i++) begin
            ea[W-1-DW*i -: DW] = lane(hist_a[i], i);
            eb[W-1-DW*i -: DW] = lane(hist_b[i], i);
        end
        chk("a_out", a_out, ea);
        chk("b_out", b_out, eb);
        if (reset) begin
            chk("ready_in_reset", in_ready, 0);
        end else if (in_valid && in_ready) begin
            part_a.push_back(in_a);
            part_b.push_back(in_b);
            if (part_a.size() == SZ) begin
                for (int i = 0; i < SZ; i++) begin q_a.push_back(part_a[i]); q_b.push_back(part_b[i]); end
                part_a.delete();
                part_b.delete();
            end
        end
        rst_prev = reset;
    end

    bit ovs [64];
    bit rcs [64];
    bit rdys[64];

    task automatic run_pattern(input int n, input logic [63:0] vmask);
        for (int c = 0; c < n; c++) begin
            in_valid = vmask[c];
            in_a = rand_vec();
            in_b = rand_vec();
            @(negedge clk);
            ovs[c] = out_valid; rcs[c] = reset_counter; rdys[c] = in_ready;
            step();
        end
        in_valid = 1'b0;
    endtask

    function automatic int first_ov(input int n);
        for (int c = 0; c < n; c++) if (ovs[c]) return c;
        return -1;
    endfunction

    function automatic int run_len(input int n, input int s);
        int len;
        len = 0;
        if (s < 0) return 0;
        for (int c = s; c < n && ovs[c]; c++) len++;
        return len;
    endfunction

    function automatic int count_rc(input int n);
        int cnt;
        cnt = 0;
        for (int c = 0; c < n; c++) if (rcs[c]) cnt++;
        return cnt;
    endfunction

    function automatic int ready_drops(input int n);
        int cnt;
        cnt = 0;
        for (int c = 0; c < n; c++) if (!rdys[c]) cnt++;
        return cnt;
    endfunction

    typedef struct {
        bit           v;
        logic [W-1:0] a, b;
        bit           e_ov, e_rc;
        logic [DW-1:0] e_a0, e_a2, e_b0;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int f;
        for (int r = 0; r < 10; r++) tbl[r] = '{default: '0};
        for (int k = 0; k < 3; k++) begin
            tbl[k].v = 1'b1;
            tbl[k].a = beat_vec(k, 16'h0000);
            tbl[k].b = beat_vec(k, 16'h0011);
            tbl[4+k].e_ov = 1'b1;
            tbl[4+k].e_a0 = DW'((3*k + 1) << 8);
            tbl[4+k].e_b0 = DW'((3*k + 1) << 8) + 16'h0011;
            tbl[6+k].e_a2 = DW'((3*k + 3) << 8);
        end
        tbl[4].e_rc = 1'b1;

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_a_out", a_out, 0);
        chk("reset_b_out", b_out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_rc", reset_counter, 0);
        chk("reset_in_ready", in_ready, 0);
        step();
        reset = 1'b0;

        // Single tile, cycle-exact
        for (int r = 0; r < 10; r++) begin
            in_valid = tbl[r].v; in_a = tbl[r].a; in_b = tbl[r].b;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", r), in_ready, 1);
            chk($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].e_ov);
            chk($sformatf("tbl%0d_rc", r), reset_counter, tbl[r].e_rc);
            chk($sformatf("tbl%0d_a_lane0", r), lane(a_out, 0), tbl[r].e_a0);
            chk($sformatf("tbl%0d_a_lane2", r), lane(a_out, 2), tbl[r].e_a2);
            chk($sformatf("tbl%0d_b_lane0", r), lane(b_out, 0), tbl[r].e_b0);
            step();
        end
        in_valid = 1'b0;

        // Two tiles back to back
        run_pattern(20, 64'h3F);
        f = first_ov(20);
        chk("b2b_first", f, 4);
        chk("b2b_run", run_len(20, f), 6);
        chk("b2b_rc0", rcs[4], 1);
        chk("b2b_rc3", rcs[7], 1);
        chk("b2b_rc_count", count_rc(20), 2);
        chk("b2b_ready_drops", ready_drops(6), 0);

        // Three tiles continuous
        run_pattern(24, 64'h1FF);
        f = first_ov(24);
        chk("tri_first", f, 4);
        chk("tri_run", run_len(24, f), 9);
        chk("tri_rc_count", count_rc(24), 3);
        chk("tri_ready_drops", ready_drops(9), 0);

        // Stalling producer: valid 1,0,0,1,0,1
        run_pattern(16, 64'b101001);
        f = first_ov(16);
        chk("stall_first", f, 7);
        chk("stall_run", run_len(16, f), 3);
        chk("stall_rc_count", count_rc(16), 1);

        // Reset while lane 0 shows beat 1
        for (int c = 0; c < 5; c++) begin
            in_valid = (c < 3); in_a = rand_vec(); in_b = rand_vec();
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_beat1_valid", out_valid, 1);
        chk("mid_beat1_rc", reset_counter, 0);
        step();
        @(negedge clk);
        chk("mid_rst_a_out", a_out, 0);
        chk("mid_rst_b_out", b_out, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_rc", reset_counter, 0);
        chk("mid_rst_ready", in_ready, 0);
        step();
        reset = 1'b0;
        run_pattern(12, 64'h7);
        f = first_ov(12);
        chk("after_rst_first", f, 4);
        chk("after_rst_run", run_len(12, f), 3);

        // Random traffic, ~1000 tiles
        for (int c = 0; c < 5000; c++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            in_a = rand_vec();
            in_b = rand_vec();
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (q_a.size() == 0) break;
            step();
        end
        chk("drain_empty", q_a.size(), 0);
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
